// File: rtl/bram_frame_reader_if.sv
// ---------------------------------------------------------------------------
// bram_frame_reader_if
// Pixel stream leaving the BRAM frame reader: a valid/ready handshake with
// start-of-frame and end-of-line markers that travel with each pixel.
//   master : the frame reader (drives data, valid and markers)
//   slave  : downstream display/processing logic (drives ready)
// ---------------------------------------------------------------------------
interface bram_frame_reader_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] m_data;   // pixel value
    logic             m_valid;  // m_data holds a pixel
    logic             m_ready;  // downstream can take the pixel this cycle
    logic             m_sof;    // pixel is (0,0) of the frame
    logic             m_eol;    // pixel is the last one of its line

    modport master (
        output m_data,
        output m_valid,
        output m_sof,
        output m_eol,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_sof,
        input  m_eol,
        output m_ready
    );
endinterface

// File: rtl/bram_frame_reader.sv
// ---------------------------------------------------------------------------
// bram_frame_reader
// Read-side companion of the single-port BRAM frame store. Sweeps an
// H_ACTIVE x V_ACTIVE frame out of the BRAM in raster order and presents it
// on a valid/ready stream, hiding the BRAM's one-cycle read latency.
//
// Datapath:
//   - r_addr is the next address to read; it is driven straight onto
//     bram_addr, so "issuing" a read means the BRAM samples r_addr at the
//     coming edge and r_addr then advances.
//   - A read in flight returns on bram_dout one cycle later. If the stream
//     is empty and the pixel is accepted that same cycle it bypasses the
//     buffer; otherwise it lands in a 2-entry FIFO on the next edge.
//   - A read is only issued while occupancy (buffer + in flight - pixel
//     leaving this cycle) is below 2, so the FIFO can never overflow and
//     m_ready held high still gives one pixel per cycle.
//
// Optional feature, selected by defining BRAM_FRAME_READER_LOOP_EN:
//   frames repeat back to back with no bubble; only rst_n leaves the loop.
//   Default build (macro undefined): one frame per start pulse.
//
// The frame must fit the BRAM: H_ACTIVE*V_ACTIVE <= 2**LOGSIZE.
// ---------------------------------------------------------------------------
module bram_frame_reader #(
    parameter int LOGSIZE  = 14,
    parameter int WIDTH    = 1,
    parameter int H_ACTIVE = 128,
    parameter int V_ACTIVE = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [LOGSIZE-1:0]     bram_addr,
    input  logic [WIDTH-1:0]       bram_dout,
    bram_frame_reader_if.master    m_if
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam int                 NPIX      = H_ACTIVE * V_ACTIVE;
    localparam logic [LOGSIZE-1:0] LAST_ADDR = LOGSIZE'(NPIX - 1);
    localparam int                 XW        = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [XW-1:0]      LAST_X    = XW'(H_ACTIVE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,   // waiting for start
        S_READ  = 2'd1,   // issuing reads as credit allows
        S_DRAIN = 2'd2    // all reads issued, emptying the pipeline
    } state_t;

    // A pixel plus the markers that must stay attached to it.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             sof;
        logic             eol;
        logic             last;   // final pixel of the frame
    } pix_t;

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    state_t             r_state;
    logic [LOGSIZE-1:0] r_addr;       // next address to read
    logic [XW-1:0]      r_x;          // column of r_addr, for the eol marker
    logic               r_inflight;   // a read was issued last cycle
    logic               r_inf_sof;    // markers of the read in flight
    logic               r_inf_eol;
    logic               r_inf_last;
    pix_t               r_buf [2];    // FIFO payload, r_buf[0] is the head
    logic [1:0]         r_count;      // FIFO occupancy, 0..2
    logic               r_done;

    // -----------------------------------------------------------------------
    // Wires
    // -----------------------------------------------------------------------
    state_t             w_state_nxt;
    pix_t               w_ret;        // pixel arriving from the BRAM now
    pix_t               w_head;       // pixel presented on the stream
    logic               w_valid;
    logic               w_hs;         // handshake this cycle
    logic [2:0]         w_occ;        // occupancy after this cycle's handshake
    logic               w_issue;      // BRAM samples r_addr at the next edge
    logic               w_at_last;    // r_addr is the final frame address
    logic               w_push;       // returning pixel must be buffered
    logic               w_pop;        // head of the FIFO leaves

    // -----------------------------------------------------------------------
    // Stream head, handshake and read credit
    // -----------------------------------------------------------------------
    // Select the presented pixel and decide whether a new read may issue.
    always_comb begin
        w_ret.data = bram_dout;
        w_ret.sof  = r_inf_sof;
        w_ret.eol  = r_inf_eol;
        w_ret.last = r_inf_last;

        w_valid   = (r_count != 2'd0) || r_inflight;
        // Older buffered pixels always go first; the BRAM output is only
        // shown directly when the FIFO is empty.
        w_head    = (r_count != 2'd0) ? r_buf[0] : w_ret;
        w_hs      = w_valid && m_if.m_ready;

        // No underflow: a handshake implies at least one pixel is present.
        w_occ     = 3'(r_count) + 3'(r_inflight) - 3'(w_hs);
        w_issue   = (r_state == S_READ) && (w_occ < 3'd2);
        w_at_last = (r_addr == LAST_ADDR);

        // A returning pixel skips the FIFO only when it is accepted at once.
        w_push    = r_inflight && !((r_count == 2'd0) && w_hs);
        w_pop     = w_hs && (r_count != 2'd0);
    end

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk) begin
        // NOTE: every clocked assignment is non-blocking so all registers
        // update from the same pre-edge values, whatever the statement order.
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first, so every path assigns w_state_nxt and no
        // latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                if (w_issue && w_at_last) begin
`ifdef BRAM_FRAME_READER_LOOP_EN
                    // Wrap to the next frame without leaving READ.
                    w_state_nxt = S_READ;
`else
                    w_state_nxt = S_DRAIN;
`endif
                end
            end
            S_DRAIN: begin
                // r_done marks the cycle after the last pixel was taken; the
                // reader is only back in IDLE after it, so a start coinciding
                // with done is not seen.
                if (r_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Address / column counter
    // -----------------------------------------------------------------------
    // Raster address as a plain incrementing counter; holds when not issuing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_addr <= '0;
            r_x    <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_addr <= '0;
            r_x    <= '0;
        end else if (w_issue) begin
            if (w_at_last) begin
`ifdef BRAM_FRAME_READER_LOOP_EN
                r_addr <= '0;
                r_x    <= '0;
`else
                // Hold on the final address; it never goes past the frame.
                r_addr <= r_addr;
                r_x    <= r_x;
`endif
            end else begin
                r_addr <= r_addr + LOGSIZE'(1);
                r_x    <= (r_x == LAST_X) ? '0 : r_x + XW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // In-flight read tracking
    // -----------------------------------------------------------------------
    // Remember whether a read is returning next cycle, and its markers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_inf_sof  <= 1'b0;
            r_inf_eol  <= 1'b0;
            r_inf_last <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            r_inf_sof  <= (r_addr == '0);
            r_inf_eol  <= (r_x == LAST_X);
            r_inf_last <= w_at_last;
        end
    end

    // -----------------------------------------------------------------------
    // Output FIFO
    // -----------------------------------------------------------------------
    // Occupancy: reset empties the FIFO, which drops any buffered pixels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= 2'd0;
        end else begin
            case ({w_pop, w_push})
                2'b10:   r_count <= r_count - 2'd1;
                2'b01:   r_count <= r_count + 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload shift/fill; entries beyond r_count are don't-care.
    always_ff @(posedge clk) begin
        // NOTE: the payload has no reset; r_count alone says which entries
        // are meaningful, so clearing the storage would buy nothing.
        case ({w_pop, w_push})
            2'b10: begin
                r_buf[0] <= r_buf[1];
            end
            2'b01: begin
                // Credit keeps occupancy at most 1 here, so index fits.
                r_buf[r_count[0]] <= w_ret;
            end
            2'b11: begin
                if (r_count == 2'd2) begin
                    r_buf[0] <= r_buf[1];
                    r_buf[1] <= w_ret;
                end else begin
                    r_buf[0] <= w_ret;
                end
            end
            default: begin
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Frame completion
    // -----------------------------------------------------------------------
    // One-cycle done pulse after the frame's final pixel is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_hs && w_head.last;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign done      = r_done;
    assign bram_addr = r_addr;

`ifdef BRAM_FRAME_READER_LOOP_EN
    assign busy = (r_state != S_IDLE);
`else
    // The done cycle is still in DRAIN but no longer counts as busy.
    assign busy = (r_state != S_IDLE) && !r_done;
`endif

    // Markers and data are forced low whenever nothing is presented.
    assign m_if.m_valid = w_valid;
    assign m_if.m_data  = w_valid ? w_head.data : '0;
    assign m_if.m_sof   = w_valid && w_head.sof;
    assign m_if.m_eol   = w_valid && w_head.eol;

endmodule
